// File: rtl/nbit_seq_divider_pkg.sv
// -----------------------------------------------------------------------------
// nbit_seq_divider_pkg
// Shared definitions for the sequential restoring divider:
//   - state_t     : controller state encoding (IDLE / CALC / DONE)
//   - DEFAULT_N   : default operand width
// No ports (package).
// -----------------------------------------------------------------------------
package nbit_seq_divider_pkg;

  localparam int DEFAULT_N = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : nbit_seq_divider_pkg

// File: rtl/nbit_seq_divider_subtractor.sv
// -----------------------------------------------------------------------------
// nbit_subtractor
// Combinational W-bit ripple-carry subtractor: diff = a - b.
// Built as a full-adder chain computing a + ~b + 1.
// Ports:
//   a      in  W  minuend
//   b      in  W  subtrahend
//   diff   out W  a - b (modulo 2^W)
//   borrow out 1  high when a < b (inverse of the final carry)
// -----------------------------------------------------------------------------
module nbit_subtractor #(
  parameter int W = 5
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] diff,
  output logic         borrow
);

  logic [W:0]   carry;
  logic [W-1:0] b_n;

  assign b_n      = ~b;
  assign carry[0] = 1'b1;

  for (genvar i = 0; i < W; i++) begin : g_fa
    assign diff[i]    = a[i] ^ b_n[i] ^ carry[i];
    assign carry[i+1] = (a[i] & b_n[i]) | (a[i] & carry[i]) | (b_n[i] & carry[i]);
  end

  assign borrow = ~carry[W];

endmodule : nbit_subtractor

// File: rtl/nbit_seq_divider.sv
// -----------------------------------------------------------------------------
// nbit_seq_divider
// Sequential restoring divider for unsigned N-bit operands; one quotient bit
// per clock through an (N+1)-bit ripple subtractor.
// Ports:
//   clk         in  1  rising-edge clock
//   rst         in  1  synchronous active-high reset
//   start       in  1  division request, honoured only in IDLE
//   dividend    in  N  unsigned dividend, captured on the accept edge
//   divisor     in  N  unsigned divisor, captured on the accept edge
//   busy        out 1  high while in CALC or DONE
//   done        out 1  one-cycle pulse when results are valid
//   quotient    out N  unsigned quotient (held until next result or reset)
//   remainder   out N  unsigned remainder (held until next result or reset)
//   div_by_zero out 1  set with done when the divisor was zero
// -----------------------------------------------------------------------------
module nbit_seq_divider
  import nbit_seq_divider_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CNT_W = $clog2(N + 1);

  state_t         state;
  logic [CNT_W-1:0] cnt;

  // Working registers: partial remainder, quotient/dividend shifter, divisor.
  logic [N:0]     r_acc;
  logic [N-1:0]   q_acc;
  logic [N-1:0]   d_reg;

  logic [N:0]     r_shift;
  logic [N:0]     diff;
  logic           borrow;
  logic [N:0]     r_next;
  logic [N-1:0]   q_next;
  logic           last_iter;

  // {R,Q} shifted left by one: the MSB of Q moves into the LSB of R.
  // R never exceeds the divisor, so its top bit shifts out as zero.
  assign r_shift = (r_acc << 1) | {{N{1'b0}}, q_acc[N-1]};

  nbit_subtractor #(
    .W (N + 1)
  ) u_sub (
    .a      (r_shift),
    .b      ({1'b0, d_reg}),
    .diff   (diff),
    .borrow (borrow)
  );

  // Restore on borrow; otherwise keep the difference and set the quotient bit.
  always_comb begin
    r_next = borrow ? r_shift : diff;
    q_next = (q_acc << 1) | {{(N-1){1'b0}}, ~borrow};
  end

  assign last_iter = (cnt == CNT_W'(N - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            d_reg <= divisor;
            q_acc <= dividend;
            r_acc <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            // A zero divisor skips the iterations and reports immediately.
            if (divisor == '0) begin
              state       <= DONE;
              done        <= 1'b1;
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              state <= CALC;
            end
          end
        end

        CALC: begin
          r_acc <= r_next;
          q_acc <= q_next;
          cnt   <= cnt + 1'b1;
          if (last_iter) begin
            state       <= DONE;
            done        <= 1'b1;
            quotient    <= q_next;
            remainder   <= r_next[N-1:0];
            div_by_zero <= 1'b0;
          end
        end

        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule : nbit_seq_divider

// File: tb/tb_nbit_seq_divider.sv
// -----------------------------------------------------------------------------
// tb_nbit_seq_divider
// Self-checking bench for nbit_seq_divider with N = 4: a table of directed
// vectors, hand-written multi-cycle sequences (start held, reset abort) and a
// full 16x16 operand sweep against a behavioural reference.
// -----------------------------------------------------------------------------
module tb_nbit_seq_divider;

  localparam int N = 4;
  localparam int LAT_LIMIT = 20;

  logic         clk;
  logic         rst;
  logic         start;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;

  nbit_seq_divider #(.N(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total_checks = 0;
  int passed_checks = 0;
  int done_cnt = 0;
  int accepts = 0;

  // done is sampled on the falling edge, once per high cycle.
  always @(negedge clk) if (done === 1'b1) done_cnt++;

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         z;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input int act, input int exp);
    total_checks++;
    if (act == exp) passed_checks++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Launch one division from an idle DUT and wait for done.
  // lat = number of rising edges after the accept edge before done is seen.
  task automatic do_div(input logic [N-1:0] a, input logic [N-1:0] b,
                        output int q, output int r, output int z, output int lat);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    accepts++;
    @(negedge clk);
    start    = 1'b0;
    dividend = ~a;
    divisor  = ~b;
    lat = 0;
    while (done !== 1'b1 && lat < LAT_LIMIT) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    q = quotient;
    r = remainder;
    z = div_by_zero;
  endtask

  int q, r, z, lat;
  int dc0;

  initial begin
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;

    tbl[0] = '{a: 4'd13, b: 4'd4, q: 4'd3,  r: 4'd1, z: 1'b0};
    tbl[1] = '{a: 4'd15, b: 4'd1, q: 4'd15, r: 4'd0, z: 1'b0};
    tbl[2] = '{a: 4'd7,  b: 4'd9, q: 4'd0,  r: 4'd7, z: 1'b0};
    tbl[3] = '{a: 4'd0,  b: 4'd5, q: 4'd0,  r: 4'd0, z: 1'b0};
    tbl[4] = '{a: 4'd9,  b: 4'd0, q: 4'd15, r: 4'd9, z: 1'b1};
    tbl[5] = '{a: 4'd6,  b: 4'd3, q: 4'd2,  r: 4'd0, z: 1'b0};
    tbl[6] = '{a: 4'd15, b: 4'd15, q: 4'd1, r: 4'd0, z: 1'b0};
    tbl[7] = '{a: 4'd0,  b: 4'd0, q: 4'd15, r: 4'd0, z: 1'b1};

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset quotient", quotient, 0);
    check("reset remainder", remainder, 0);
    check("reset div_by_zero", div_by_zero, 0);

    // Directed table
    foreach (tbl[i]) begin
      do_div(tbl[i].a, tbl[i].b, q, r, z, lat);
      check($sformatf("tbl%0d latency", i), lat, (tbl[i].b == 0) ? 0 : N);
      check($sformatf("tbl%0d busy", i), busy, 1);
      check($sformatf("tbl%0d quotient", i), q, tbl[i].q);
      check($sformatf("tbl%0d remainder", i), r, tbl[i].r);
      check($sformatf("tbl%0d div_by_zero", i), z, tbl[i].z);
      @(posedge clk); @(negedge clk);
      check($sformatf("tbl%0d done one cycle", i), done, 0);
      check($sformatf("tbl%0d busy falls", i), busy, 0);
      check($sformatf("tbl%0d quotient held", i), quotient, tbl[i].q);
    end

    // start held high through CALC with operands changed: second request
    // is not taken until IDLE, then accepted with the new operands.
    @(negedge clk);
    dividend = 4'd12; divisor = 4'd5; start = 1'b1;
    @(posedge clk); accepts++;
    @(negedge clk);
    dividend = 4'd3; divisor = 4'd1;
    lat = 0;
    while (done !== 1'b1 && lat < LAT_LIMIT) begin
      @(posedge clk); lat++; @(negedge clk);
    end
    check("held latency", lat, N);
    check("held quotient", quotient, 2);
    check("held remainder", remainder, 2);
    @(posedge clk); @(negedge clk);
    check("held idle busy", busy, 0);
    @(posedge clk); accepts++;
    @(negedge clk);
    check("held reaccept busy", busy, 1);
    start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < LAT_LIMIT) begin
      @(posedge clk); lat++; @(negedge clk);
    end
    check("second latency", lat, N);
    check("second quotient", quotient, 3);
    check("second remainder", remainder, 0);
    @(posedge clk); @(negedge clk);

    // Reset during the second CALC cycle of 14/3 aborts with no done.
    dc0 = done_cnt;
    @(negedge clk);
    dividend = 4'd14; divisor = 4'd3; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    check("abort quotient", quotient, 0);
    check("abort remainder", remainder, 0);
    check("abort div_by_zero", div_by_zero, 0);
    repeat (8) @(negedge clk);
    check("abort no done pulse", done_cnt, dc0);
    do_div(4'd14, 4'd3, q, r, z, lat);
    check("fresh latency", lat, N);
    check("fresh quotient", q, 4);
    check("fresh remainder", r, 2);
    check("fresh div_by_zero", z, 0);
    @(posedge clk); @(negedge clk);

    // Full sweep against a behavioural reference.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        int eq, er, ez;
        if (b == 0) begin
          eq = 15; er = a; ez = 1;
        end else begin
          eq = a / b; er = a % b; ez = 0;
        end
        do_div(4'(a), 4'(b), q, r, z, lat);
        check($sformatf("sweep %0d/%0d latency", a, b), lat, (b == 0) ? 0 : N);
        check($sformatf("sweep %0d/%0d quotient", a, b), q, eq);
        check($sformatf("sweep %0d/%0d remainder", a, b), r, er);
        check($sformatf("sweep %0d/%0d div_by_zero", a, b), z, ez);
        @(posedge clk); @(negedge clk);
      end
    end

    check("done pulses per accept", done_cnt, accepts);

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule : tb_nbit_seq_divider
